// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver.
// The line is sampled at OVERSAMPLE ticks per bit. The start bit is
// confirmed at mid-bit, and data bits are shifted in LSB first. Each
// correctly framed byte is presented on q_out with a one-clock valid
// strobe. A stop bit that samples low gives a one-clock frame_err
// strobe instead, and q_out keeps its old value.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 s_in,
    output logic [DATA_BITS-1:0] q_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync_meta, sync_line;
    logic                 prev_q;
    logic                 stop_tick, good_stop, bad_stop;

    // Two-flop synchronizer. It resets to the idle-high line level so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
        end else begin
            sync_meta <= s_in;
            sync_line <= sync_meta;
        end
    end

    // State, counters, the shift register and the registered strobes. The
    // strobes self-clear every clock, even when clk_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            prev_q    <= 1'b1;
            q_out     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid     <= good_stop;
            frame_err <= bad_stop;
            if (clk_en) begin
                prev_q <= sync_line;
            end
            if (good_stop) begin
                q_out <= shift_q;
            end
        end
    end

    // Next-state and counter logic. Nothing advances without a sample tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (prev_q && !sync_line) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        if (!sync_line) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                            tick_d  = '0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_LAST) begin
                        shift_d = {sync_line, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == FULL_LAST) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Output decode: busy follows the state, and the mid-stop-bit sample
    // decides which strobe fires on the next clock.
    always_comb begin
        busy      = (state_q != IDLE);
        stop_tick = clk_en && (state_q == STOP) && (tick_q == FULL_LAST);
        good_stop = stop_tick && sync_line;
        bad_stop  = stop_tick && !sync_line;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed expected bytes, strobe
// counts, busy behaviour and valid latency for uart_rx.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic       s_in = 1'b1;
    logic [7:0] q_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int check_count = 0;
    int pass_count  = 0;

    int         en_period = 1;
    int         en_cnt = 0;
    int         cycle = 0;
    int         valid_count = 0;
    int         ferr_count = 0;
    int         both_count = 0;
    int         last_valid_cycle = 0;
    int         valid_run = 0;
    int         ferr_run = 0;
    int         max_valid_run = 0;
    int         max_ferr_run = 0;
    logic [7:0] captured [0:15];

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .s_in     (s_in),
        .q_out    (q_out),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count clock edges so that latencies can be measured in clocks.
    always @(posedge clk) cycle <= cycle + 1;

    // Generate the sample tick: one clk in en_period.
    always @(negedge clk) begin
        clk_en <= (en_cnt == 0);
        en_cnt <= (en_cnt >= en_period - 1) ? 0 : en_cnt + 1;
    end

    // Watch the strobes: count them, capture the bytes and track pulse widths.
    always @(negedge clk) begin
        if (valid) begin
            if (valid_count < 16) captured[valid_count] <= q_out;
            valid_count      <= valid_count + 1;
            last_valid_cycle <= cycle;
        end
        if (frame_err) ferr_count <= ferr_count + 1;
        if (valid && frame_err) both_count <= both_count + 1;
        valid_run <= valid ? valid_run + 1 : 0;
        ferr_run  <= frame_err ? ferr_run + 1 : 0;
        if (valid && (valid_run + 1 > max_valid_run)) max_valid_run <= valid_run + 1;
        if (frame_err && (ferr_run + 1 > max_ferr_run)) max_ferr_run <= ferr_run + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame, LSB first. The line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int bit_clks);
        s_in = 1'b0;
        waitClocks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            s_in = data[i];
            waitClocks(bit_clks);
        end
        s_in = stop_bit;
        waitClocks(bit_clks);
    endtask

    initial begin
        int v0, f0, c0, lat, busy_cnt;

        waitClocks(3);
        rst = 1'b0;
        waitClocks(2);
        checkOutput("reset_q_out", q_out, 8'h00);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        waitClocks(20);

        // Test 1: single frame 0xF0, latency measured from the falling edge.
        v0 = valid_count; f0 = ferr_count; c0 = cycle;
        applyStimulus(8'hF0, 1'b1, 16);
        waitClocks(24);
        lat = last_valid_cycle - c0;
        checkOutput("t1_valid_count", valid_count - v0, 1);
        checkOutput("t1_q_out", q_out, 8'hF0);
        checkOutput("t1_frame_err", ferr_count - f0, 0);
        checkOutput("t1_busy_after", busy, 1'b0);
        checkOutput("t1_latency_in_range", (lat >= 151 && lat <= 157), 1'b1);

        // Test 2: 0x00 then 0x55 back-to-back.
        v0 = valid_count; f0 = ferr_count;
        applyStimulus(8'h00, 1'b1, 16);
        applyStimulus(8'h55, 1'b1, 16);
        waitClocks(24);
        checkOutput("t2_valid_count", valid_count - v0, 2);
        checkOutput("t2_first_byte", captured[v0], 8'h00);
        checkOutput("t2_second_byte", captured[v0+1], 8'h55);
        checkOutput("t2_frame_err", ferr_count - f0, 0);

        // Test 3: 4-clk glitch on an idle line.
        v0 = valid_count; f0 = ferr_count; busy_cnt = 0;
        s_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        s_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        checkOutput("t3_busy_seen", (busy_cnt > 0), 1'b1);
        checkOutput("t3_busy_short", (busy_cnt <= 12), 1'b1);
        checkOutput("t3_busy_after", busy, 1'b0);
        checkOutput("t3_no_valid", valid_count - v0, 0);
        checkOutput("t3_no_frame_err", ferr_count - f0, 0);
        checkOutput("t3_q_out_kept", q_out, 8'h55);

        // Test 4: 0xA5 with a low stop bit, then the line is held low.
        v0 = valid_count; f0 = ferr_count;
        applyStimulus(8'hA5, 1'b0, 16);
        waitClocks(100);
        checkOutput("t4_frame_err_count", ferr_count - f0, 1);
        checkOutput("t4_no_valid", valid_count - v0, 0);
        checkOutput("t4_q_out_kept", q_out, 8'h55);
        checkOutput("t4_no_retrigger", busy, 1'b0);
        checkOutput("t4_frame_err_width", max_ferr_run, 1);
        s_in = 1'b1;
        waitClocks(32);
        v0 = valid_count;
        applyStimulus(8'h3C, 1'b1, 16);
        waitClocks(24);
        checkOutput("t4_recover_valid", valid_count - v0, 1);
        checkOutput("t4_recover_byte", q_out, 8'h3C);

        // Test 5: sample tick one clk in four, 64 clk per bit.
        en_period = 4;
        waitClocks(16);
        v0 = valid_count; f0 = ferr_count;
        applyStimulus(8'h3C, 1'b1, 64);
        waitClocks(80);
        checkOutput("t5_valid_count", valid_count - v0, 1);
        checkOutput("t5_q_out", captured[v0], 8'h3C);
        checkOutput("t5_valid_width", max_valid_run, 1);
        checkOutput("t5_frame_err", ferr_count - f0, 0);
        en_period = 1;
        waitClocks(16);

        // Test 6: reset during data bit 3 of 0xFF, then 0x81.
        v0 = valid_count; f0 = ferr_count;
        s_in = 1'b0;
        waitClocks(16);
        s_in = 1'b1;
        waitClocks(48 + 8);
        checkOutput("t6_busy_before_reset", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_busy_after_reset", busy, 1'b0);
        checkOutput("t6_q_out_after_reset", q_out, 8'h00);
        waitClocks(120);
        checkOutput("t6_no_strobes", (valid_count - v0) + (ferr_count - f0), 0);
        v0 = valid_count;
        applyStimulus(8'h81, 1'b1, 16);
        waitClocks(24);
        checkOutput("t6_valid_count", valid_count - v0, 1);
        checkOutput("t6_q_out", q_out, 8'h81);

        checkOutput("never_both_strobes", both_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver, the receive-side counterpart of the team's 8N1 transmitter. It samples the asynchronous line s_in at OVERSAMPLE times the bit rate and validates the start bit at mid-bit. It shifts in DATA_BITS LSB-first, checks the stop bit, and presents each byte on q_out with a one-cycle valid strobe. It sits between the board RX pin and any byte-consuming logic (FIFO, command decoder).

Parameters:
OVERSAMPLE, 16, clk_en ticks per bit period; even, >= 4.
DATA_BITS, 8, data bits per frame (no parity, one stop bit).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
clk_en  input  1  sample tick at OVERSAMPLE x baud; state advances only when high.
s_in  input  1  asynchronous serial line, idle high.
q_out  output  DATA_BITS  last correctly framed byte; held until next good frame.
valid  output  1  one-clk pulse when q_out updates.
busy  output  1  high from start-bit detection until return to IDLE.
frame_err  output  1  one-clk pulse when stop bit samples low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset (rst high at clk edge): state=IDLE, tick/bit counters=0, shift reg=0, q_out=0, valid=0, busy=0, frame_err=0, synchronizer flops=1, prev-sample=1. Reset wins over every other event, including mid-frame.
- s_in passes through a 2-FF synchronizer (reset to 1); all decisions use the synchronized value. This adds 2 clk of latency.
- With clk_en low, state, counters and prev-sample freeze. valid and frame_err still self-clear after one clk.
- States: IDLE, START, DATA, STOP.
- IDLE: on a tick with prev-sample=1 and sample=0 (falling edge), go to START, tick count=0, busy=1. A line held low never retriggers.
- START: count ticks. At count=OVERSAMPLE/2-1 (mid start bit), a sample of 0 goes to DATA with count=0 and bit=0. A sample of 1 is a glitch: go to IDLE, busy=0, no strobes.
- DATA: at count=OVERSAMPLE-1, sample into shift reg MSB side (shift right, LSB first on wire), reset count, bit++. After sample number DATA_BITS, go to STOP.
- STOP: at count=OVERSAMPLE-1, sample the stop bit.
  - Sample 1: q_out<=shift reg and valid=1 on the next clk.
  - Sample 0: frame_err=1 on the next clk, q_out unchanged, valid stays 0.
  - Either way go to IDLE, busy=0.
- Return to IDLE happens at mid stop bit. An immediately following start edge (back-to-back frames) is therefore detected.
- valid and frame_err are never high together and are each exactly one clk wide.
- Latency: valid rises ~(DATA_BITS+1.5) bit periods + 2-3 clk after the start-bit falling edge.
- Tolerates up to about ±4% baud mismatch. No resynchronization within a frame.

Test Plan:
Defaults unless stated: OVERSAMPLE=16, clk_en=1 every clk, bit period 16 clk.

1. Frame 0xF0 (start 0, bits 0,0,0,0,1,1,1,1, stop 1) -> one valid pulse ~154±3 clk after the falling edge, q_out=0xF0, frame_err never high, busy low afterward.
2. 0x00 then 0x55 back-to-back, no idle gap -> two valid pulses, q_out=0x00 then 0x55, no frame_err.
3. 4-clk low glitch on an idle line -> busy high ≤ ~12 clk, then 0. No valid, no frame_err, q_out unchanged.
4. Frame 0xA5 with stop bit 0, then line held low 100 clk -> one frame_err pulse, no valid, q_out keeps its previous value. No new start until the line goes high then low. A following 0x3C frame is received correctly.
5. clk_en high 1 clk in 4 (bit period 64 clk), frame 0x3C -> valid once, q_out=0x3C. valid pulse is 1 clk wide, not 4.
6. rst pulsed during data bit 3 of 0xFF -> next clk busy=0, q_out=0x00, no strobes. A subsequent frame 0x81 is received as 0x81.
